alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Integer execute unit of the 5-stage MIPS pipeline: decodes ALUop/funct into a
//   4-bit ALU operation and computes a 32-bit result plus 8-bit status. It also
//   holds the ID-stage forwarding selectors (F1/F2) for early branch compare.
//   Result/status are available combinationally and as a 1-cycle registered copy.
// PARAMETERS
//   none (datapath fixed at 32 bits, register index 5 bits)
// PORTS
//   clk              in   1   single clock; all state updates on rising edge
//   reset            in   1   synchronous, active-high reset
//   alu_op           in   2   from ID/EX control: 00 add, 01 sub, 10 R-type, 11 or
//   funct            in   6   instruction[5:0] (sign-extend low bits)
//   shamt            in   5   instruction[10:6]
//   src_a            in   32  operand A (rs, already forwarded)
//   src_b            in   32  operand B (rt or sign-extended immediate)
//   alu_ctrl         out  4   decoded ALU operation
//   result           out  32  combinational ALU result
//   status           out  8   combinational ALU status
//   result_q         out  32  result registered 1 cycle
//   status_q         out  8   status registered 1 cycle
//   id_ex_regwrite   in   1   instruction in EX writes a register
//   ex_mem_regwrite  in   1   instruction in MEM writes a register
//   id_ex_rd         in   5   destination index of EX instruction
//   ex_mem_rd        in   5   destination index of MEM instruction
//   if_id_rs         in   5   rs of instruction in ID
//   if_id_rt         in   5   rt of instruction in ID
//   f1, f2           out  2   forward select for rs / rt: 00 regfile, 01 EX, 10 MEM
// BEHAVIOUR
//   ALU control (combinational):
//   - alu_op 00 -> 0010 add; 01 -> 0110 sub; 11 -> 0001 or.
//   - alu_op 10 by funct: 100000 add 0010, 100010 sub 0110, 100100 and 0000,
//     100101 or 0001, 100110 xor 1010, 100111 nor 1100, 101010 slt 0111,
//     000000 sll 1000, 000010 srl 1001, 000011 sra 1011; any other funct -> 1111.
//   ALU (combinational, 32-bit two's complement, results wrap mod 2^32):
//   - add a+b; sub a-b; and/or/xor/nor bitwise; slt = 1 if signed a<b else 0.
//   - sll b<<shamt, srl logical b>>shamt, sra arithmetic b>>>shamt (shamt 0 = b).
//   - 1111 (invalid): result 0.
//   - status[0] zero (result==0); [1] negative (result[31]);
//     [2] signed overflow, add/sub only (operands same sign for add / differing
//     sign for sub, result sign differs from a); [3] carry out of bit 31
//     (add: carry; sub: borrow, i.e. a<b unsigned); [4] invalid op; [7:5] = 0.
//   - overflow/carry are 0 for every non add/sub operation.
//   Registered outputs:
//   - result_q/status_q <= result/status every cycle (no enable); latency 1.
//   - reset high at a rising edge: result_q=0, status_q=0 on that edge; reset
//     wins over new data. Combinational outputs are unaffected by reset.
//   Forwarding (combinational, independent per operand):
//   - f1 = 01 if id_ex_regwrite && id_ex_rd!=0 && id_ex_rd==if_id_rs;
//     else 10 if ex_mem_regwrite && ex_mem_rd!=0 && ex_mem_rd==if_id_rs; else 00.
//   - f2 identical using if_id_rt. EX match has priority when both match.
//   - Register 0 is never forwarded; code 11 is never produced.
// TESTING
//   - alu_op=10 funct=100000 a=7 b=5 -> alu_ctrl=0010 result=12 status=00; next edge result_q=12.
//   - sub a=0x80000000 b=1 -> result=0x7FFFFFFF, status[2]=1; add 0xFFFFFFFF+1 -> 0, status[0]=1, [3]=1.
//   - slt a=-1 b=1 -> 1; sra b=0x80000000 shamt=4 -> 0xF8000000; srl same -> 0x08000000.
//   - funct=111111 with alu_op=10 -> alu_ctrl=1111, result=0, status=0x11.
//   - rs=3, id_ex_rd=3 & ex_mem_rd=3 both writing -> f1=01; id_ex_regwrite=0 -> f1=10; rd=0 -> f1=00.
//   - result_q=nonzero, assert reset one cycle -> result_q=0, status_q=0 after that edge; resumes next edge.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Integer execute unit: ALU control decode, 32-bit ALU with status flags,
// a one-cycle registered copy of result/status, and ID-stage forwarding selects.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] result,
    output logic [7:0]  status,
    output logic [31:0] result_q,
    output logic [7:0]  status_q,
    input  logic        id_ex_regwrite,
    input  logic        ex_mem_regwrite,
    input  logic [4:0]  id_ex_rd,
    input  logic [4:0]  ex_mem_rd,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    output logic [1:0]  f1,
    output logic [1:0]  f2
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_SLL = 4'b1000;
    localparam logic [3:0] CTRL_SRL = 4'b1001;
    localparam logic [3:0] CTRL_XOR = 4'b1010;
    localparam logic [3:0] CTRL_SRA = 4'b1011;
    localparam logic [3:0] CTRL_NOR = 4'b1100;
    localparam logic [3:0] CTRL_INV = 4'b1111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic [32:0] sum_ext;
    logic [32:0] diff_ext;
    logic        add_ovf;
    logic        sub_ovf;
    logic        invalid_op;
    logic        ovf_flag;
    logic        carry_flag;
    logic [31:0] result_d;
    logic [7:0]  status_d;

    always_comb begin
        alu_ctrl = CTRL_INV;
        unique case (alu_op)
            2'b00: alu_ctrl = CTRL_ADD;
            2'b01: alu_ctrl = CTRL_SUB;
            2'b11: alu_ctrl = CTRL_OR;
            default: begin
                case (funct)
                    6'b100000: alu_ctrl = CTRL_ADD;
                    6'b100010: alu_ctrl = CTRL_SUB;
                    6'b100100: alu_ctrl = CTRL_AND;
                    6'b100101: alu_ctrl = CTRL_OR;
                    6'b100110: alu_ctrl = CTRL_XOR;
                    6'b100111: alu_ctrl = CTRL_NOR;
                    6'b101010: alu_ctrl = CTRL_SLT;
                    6'b000000: alu_ctrl = CTRL_SLL;
                    6'b000010: alu_ctrl = CTRL_SRL;
                    6'b000011: alu_ctrl = CTRL_SRA;
                    default:   alu_ctrl = CTRL_INV;
                endcase
            end
        endcase
    end

    // Bit 32 of the extended difference is the unsigned borrow (a < b).
    assign sum_ext  = {1'b0, src_a} + {1'b0, src_b};
    assign diff_ext = {1'b0, src_a} - {1'b0, src_b};
    assign add_ovf  = (src_a[31] == src_b[31]) && (sum_ext[31] != src_a[31]);
    assign sub_ovf  = (src_a[31] != src_b[31]) && (diff_ext[31] != src_a[31]);

    always_comb begin
        result     = 32'd0;
        invalid_op = 1'b0;
        ovf_flag   = 1'b0;
        carry_flag = 1'b0;
        case (alu_ctrl)
            CTRL_ADD: begin
                result     = sum_ext[31:0];
                ovf_flag   = add_ovf;
                carry_flag = sum_ext[32];
            end
            CTRL_SUB: begin
                result     = diff_ext[31:0];
                ovf_flag   = sub_ovf;
                carry_flag = diff_ext[32];
            end
            CTRL_AND: result = src_a & src_b;
            CTRL_OR:  result = src_a | src_b;
            CTRL_XOR: result = src_a ^ src_b;
            CTRL_NOR: result = ~(src_a | src_b);
            CTRL_SLT: result = {31'd0, ($signed(src_a) < $signed(src_b))};
            CTRL_SLL: result = src_b << shamt;
            CTRL_SRL: result = src_b >> shamt;
            CTRL_SRA: result = $unsigned($signed(src_b) >>> shamt);
            default: begin
                result     = 32'd0;
                invalid_op = 1'b1;
            end
        endcase
    end

    assign status = {3'b000, invalid_op, carry_flag, ovf_flag, result[31], (result == 32'd0)};

    assign result_d = result;
    assign status_d = status;

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= 32'd0;
            status_q <= 8'd0;
        end else begin
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    // EX-stage producer is newer than MEM, so it wins when both match; r0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (id_ex_regwrite && (id_ex_rd != 5'd0) && (id_ex_rd == src))
            return FWD_EX;
        else if (ex_mem_regwrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == src))
            return FWD_MEM;
        else
            return FWD_REG;
    endfunction

    assign f1 = fwd_sel(if_id_rs);
    assign f2 = fwd_sel(if_id_rt);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: reference model, registered-output
// scoreboard, directed corner cases, random ALU and forwarding stimulus.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic [7:0]  status;
    logic [31:0] result_q;
    logic [7:0]  status_q;
    logic        id_ex_regwrite;
    logic        ex_mem_regwrite;
    logic [4:0]  id_ex_rd;
    logic [4:0]  ex_mem_rd;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic [1:0]  f1;
    logic [1:0]  f2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [39:0] exp_q[$];

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .alu_op(alu_op), .funct(funct), .shamt(shamt),
        .src_a(src_a), .src_b(src_b), .alu_ctrl(alu_ctrl), .result(result),
        .status(status), .result_q(result_q), .status_q(status_q),
        .id_ex_regwrite(id_ex_regwrite), .ex_mem_regwrite(ex_mem_regwrite),
        .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .if_id_rs(if_id_rs),
        .if_id_rt(if_id_rt), .f1(f1), .f2(f2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // reference model
    function automatic logic [3:0] m_ctrl(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 4'h2;
        if (op == 2'b01) return 4'h6;
        if (op == 2'b11) return 4'h1;
        case (fn)
            6'h20: return 4'h2;
            6'h22: return 4'h6;
            6'h24: return 4'h0;
            6'h25: return 4'h1;
            6'h26: return 4'hA;
            6'h27: return 4'hC;
            6'h2A: return 4'h7;
            6'h00: return 4'h8;
            6'h02: return 4'h9;
            6'h03: return 4'hB;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [39:0] m_alu(input logic [3:0] c, input logic [4:0] sh,
                                          input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub, full;
        longint sa, sb, sres;
        logic [31:0] r;
        logic ov, cy, inv;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'd0; ov = 1'b0; cy = 1'b0; inv = 1'b0;
        case (c)
            4'h2: begin
                full = ua + ub; r = full[31:0]; cy = full[32];
                sres = sa + sb; ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            4'h6: begin
                r = a - b; cy = (ua < ub);
                sres = sa - sb; ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'hA: r = a ^ b;
            4'hC: r = ~(a | b);
            4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'h8: r = b << sh;
            4'h9: r = b >> sh;
            4'hB: r = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            default: inv = 1'b1;
        endcase
        return {r, 3'b000, inv, cy, ov, r[31], (r == 32'd0)};
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src, input logic exw, input logic [4:0] exrd,
                                         input logic memw, input logic [4:0] memrd);
        if (exw && exrd != 5'd0 && exrd == src) return 2'b01;
        if (memw && memrd != 5'd0 && memrd == src) return 2'b10;
        return 2'b00;
    endfunction

    // driver: apply one operation, check combinational outputs, then check the registered copy
    task automatic do_op(input string tag, input logic rst, input logic [1:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
        logic [3:0]  ec;
        logic [39:0] em;
        logic [39:0] got;
        @(negedge clk);
        reset = rst; alu_op = op; funct = fn; shamt = sh; src_a = a; src_b = b;
        #1;
        ec = m_ctrl(op, fn);
        em = m_alu(ec, sh, a, b);
        check({tag, ".ctrl"}, 64'(alu_ctrl), 64'(ec));
        check({tag, ".result"}, 64'(result), 64'(em[39:8]));
        check({tag, ".status"}, 64'(status), 64'(em[7:0]));
        exp_q.push_back(rst ? 40'd0 : em);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue_empty"}, 64'd1, 64'd0);
        end else begin
            got = exp_q.pop_front();
            check({tag, ".result_q"}, 64'(result_q), 64'(got[39:8]));
            check({tag, ".status_q"}, 64'(status_q), 64'(got[7:0]));
        end
    endtask

    task automatic do_fwd(input string tag, input logic exw, input logic [4:0] exrd, input logic memw,
                          input logic [4:0] memrd, input logic [4:0] rs, input logic [4:0] rt);
        @(negedge clk);
        id_ex_regwrite = exw; id_ex_rd = exrd; ex_mem_regwrite = memw; ex_mem_rd = memrd;
        if_id_rs = rs; if_id_rt = rt;
        #1;
        check({tag, ".f1"}, 64'(f1), 64'(m_fwd(rs, exw, exrd, memw, memrd)));
        check({tag, ".f2"}, 64'(f2), 64'(m_fwd(rt, exw, exrd, memw, memrd)));
    endtask

    logic [5:0] funct_list [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};

    initial begin
        reset = 1'b1; alu_op = 2'b00; funct = 6'd0; shamt = 5'd0; src_a = 32'd0; src_b = 32'd0;
        id_ex_regwrite = 1'b0; ex_mem_regwrite = 1'b0; id_ex_rd = 5'd0; ex_mem_rd = 5'd0;
        if_id_rs = 5'd0; if_id_rt = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.result_q", 64'(result_q), 64'd0);
        check("reset.status_q", 64'(status_q), 64'd0);

        // directed corner cases
        do_op("add_r",     1'b0, 2'b10, 6'h20, 5'd0, 32'd7, 32'd5);
        check("add_r.literal", 64'(result_q), 64'd12);
        do_op("sub_ovf",   1'b0, 2'b01, 6'h00, 5'd0, 32'h8000_0000, 32'd1);
        check("sub_ovf.literal", 64'(status_q[2]), 64'd1);
        do_op("add_carry", 1'b0, 2'b00, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd1);
        check("add_carry.literal", 64'(status_q), 64'h09);
        do_op("slt_neg",   1'b0, 2'b10, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg.literal", 64'(result_q), 64'd1);
        do_op("sra",       1'b0, 2'b10, 6'h03, 5'd4, 32'd0, 32'h8000_0000);
        check("sra.literal", 64'(result_q), 64'hF800_0000);
        do_op("srl",       1'b0, 2'b10, 6'h02, 5'd4, 32'd0, 32'h8000_0000);
        check("srl.literal", 64'(result_q), 64'h0800_0000);
        do_op("sll0",      1'b0, 2'b10, 6'h00, 5'd0, 32'd0, 32'h1234_5678);
        do_op("invalid",   1'b0, 2'b10, 6'h3F, 5'd3, 32'd9, 32'd9);
        check("invalid.literal", 64'(status_q), 64'h11);
        do_op("or_imm",    1'b0, 2'b11, 6'h3F, 5'd0, 32'hF0F0_0000, 32'h0000_0F0F);
        do_op("sub_borrow",1'b0, 2'b01, 6'h00, 5'd0, 32'd1, 32'd2);

        // reset mid-stream wins over new data, then registered path resumes
        do_op("pre_rst",   1'b0, 2'b00, 6'h00, 5'd0, 32'd100, 32'd23);
        do_op("in_rst",    1'b1, 2'b00, 6'h00, 5'd0, 32'd55, 32'd45);
        do_op("post_rst",  1'b0, 2'b00, 6'h00, 5'd0, 32'd55, 32'd45);

        // random ALU stimulus
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  op;
            logic [5:0]  fn;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : funct_list[$urandom_range(0, 9)];
            a  = ($urandom_range(0, 3) == 0) ? {1'b1, 31'($urandom)} : $urandom;
            b  = ($urandom_range(0, 4) == 0) ? a : $urandom;
            do_op("rand", 1'b0, op, fn, 5'($urandom_range(0, 31)), a, b);
        end

        // forwarding: directed then random with small register range to force matches
        do_fwd("fwd_both",  1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 5'd4);
        check("fwd_both.literal", 64'(f1), 64'd1);
        do_fwd("fwd_mem",   1'b0, 5'd3, 1'b1, 5'd3, 5'd3, 5'd3);
        check("fwd_mem.literal", 64'(f1), 64'd2);
        do_fwd("fwd_zero",  1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        check("fwd_zero.literal", 64'(f1), 64'd0);
        do_fwd("fwd_rt",    1'b1, 5'd7, 1'b1, 5'd9, 5'd1, 5'd9);
        for (int i = 0; i < 100; i++) begin
            do_fwd("fwd_rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
